// File: rtl/mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_arbiter: round-robin share of one serial GF multiplier among N users.  |
// | Optional WAIT timeout: MUL_ARB_TIMEOUT_EN.          Rev 1.0                |
// +----------------------------------------------------------------------------+
module mul_arbiter #(
  parameter int D        = 4,
  parameter int N        = 4,
  parameter int TO_SLACK = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*(8+D)-1:0] req_p1,
  input  logic [N*(8+D)-1:0] req_p2,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       rsp_valid,
  output logic [8+D-1:0]     rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               mul_start,
  output logic [8+D-1:0]     mul_p1,
  output logic [8+D-1:0]     mul_p2,
  input  logic               mul_done,
  input  logic [8+D-1:0]     mul_out
);
  localparam int W  = 8 + D;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr, winner, sel;
  logic          req_any;
  logic          timeout;

  // First requester at or above rr_ptr, wrapping modulo N.
  always_comb begin
    sel     = rr_ptr;
    req_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!req_any && req[(int'(rr_ptr) + k) % N]) begin
        req_any = 1'b1;
        sel     = IW'((int'(rr_ptr) + k) % N);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_any) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (mul_done || timeout) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      winner   <= '0;
      mul_p1   <= '0;
      mul_p2   <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (req_any) begin
          winner <= sel;
          mul_p1 <= req_p1[int'(sel)*W +: W];
          mul_p2 <= req_p2[int'(sel)*W +: W];
        end
        S_START: rr_ptr <= IW'((int'(winner) + 1) % N);
        S_WAIT: begin
          if (mul_done)     rsp_data <= mul_out;
          else if (timeout) rsp_data <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int TO_LIMIT = 8 + D + TO_SLACK;
  localparam int CW       = $clog2(TO_LIMIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (state == S_START) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + CW'(1);
      if (mul_done)     err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end

  // A done arriving on the expiry cycle still counts as normal completion.
  assign timeout = (state == S_WAIT) && !mul_done && (wait_cnt == CW'(TO_LIMIT - 1));
  assign rsp_err = err_q && (state == S_DONE);
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    if (state == S_START) gnt[winner]       = 1'b1;
    if (state == S_DONE)  rsp_valid[winner] = 1'b1;
  end

  assign mul_start = (state == S_START);
  assign busy      = (state != S_IDLE);

endmodule
`default_nettype wire
